data_forward_helper: RTL and testbench
======================================

DATA_FORWARD_HELPER -- requirements
Module: data_forward_helper

Interface
REQ-001 Parameter XLEN, default 32, data path width in bits.
REQ-002 Parameter OPW, default 7, opcode width in bits; fixed at 7 for RV32I, and other values are unsupported.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all registered outputs.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  qualifies main_data, sub_data and opcode for the registered path.
REQ-007 main_data  input  XLEN  ALU/immediate result (LUI, AUIPC, OP-IMM, OP).
REQ-008 sub_data  input  XLEN  secondary result: link address PC+4 (JAL, JALR) or load data (LOAD).
REQ-009 opcode  input  7  RV32I opcode field, instr[6:0].
REQ-010 data_to_forward  output  XLEN  combinational forward value.
REQ-011 fwd_en  output  1  combinational; 1 when opcode produces an rd value.
REQ-012 illegal_op  output  1  combinational; 1 when opcode is not a recognised RV32I opcode.
REQ-013 data_to_forward_q  output  XLEN  registered data_to_forward.
REQ-014 fwd_en_q  output  1  registered fwd_en, gated by in_valid.
REQ-015 illegal_op_q  output  1  registered illegal_op, gated by in_valid.

Function
REQ-016 The block SHALL drive data_to_forward = main_data when opcode is 0110111 (LUI), 0010111 (AUIPC), 0010011 (OP-IMM) or 0110011 (OP); for these opcodes fwd_en=1 and illegal_op=0.
REQ-017 The block SHALL drive data_to_forward = sub_data when opcode is 1101111 (JAL), 1100111 (JALR) or 0000011 (LOAD); for these opcodes fwd_en=1 and illegal_op=0.
REQ-018 The block SHALL drive data_to_forward = 0, fwd_en=0 and illegal_op=0 when opcode is 1100011 (BRANCH), 0100011 (STORE), 0001111 (MISC-MEM) or 1110011 (SYSTEM).
REQ-019 For any other opcode, the block SHALL drive data_to_forward = 0, fwd_en=0 and illegal_op=1.
REQ-020 The combinational outputs SHALL depend only on main_data, sub_data and opcode, with zero cycle latency, and SHALL be independent of in_valid, clk and rst.
REQ-021 On each rising clk edge with rst=0 and in_valid=1, the registers SHALL capture: data_to_forward_q<=data_to_forward, fwd_en_q<=fwd_en, illegal_op_q<=illegal_op.
REQ-022 On a rising clk edge with rst=0 and in_valid=0, the registers SHALL load data_to_forward_q<=0, fwd_en_q<=0 and illegal_op_q<=0 (bubble).
REQ-023 Registered-path latency SHALL be exactly one cycle from the input to the *_q outputs.
REQ-024 Input X/Z on unused data inputs SHALL NOT propagate: the unselected operand SHALL be fully masked.
REQ-025 The block SHALL contain no state other than the three *_q registers, and SHALL have no combinational path from *_q back to any input.

Reset
REQ-026 When rst=1 at a rising clk edge, data_to_forward_q, fwd_en_q and illegal_op_q SHALL all become 0, regardless of in_valid.
REQ-027 Reset SHALL take priority over in_valid when both are asserted in the same cycle.
REQ-028 Reset SHALL NOT affect the combinational outputs.
REQ-029 Reset asserted mid-stream SHALL discard the captured value; the first in_valid cycle after rst deasserts SHALL produce valid *_q one cycle later.

Verification
REQ-030 Bench SHALL apply main_data=0x00000001, sub_data=0x00000002 and sweep LUI, AUIPC, OP-IMM, OP -> data_to_forward=0x00000001, fwd_en=1, illegal_op=0.
REQ-031 Same data, sweep JAL, JALR, LOAD -> data_to_forward=0x00000002, fwd_en=1, illegal_op=0.
REQ-032 Same data, sweep BRANCH, STORE, MISC-MEM, SYSTEM -> data_to_forward=0, fwd_en=0, illegal_op=0; opcode 1111111 -> data_to_forward=0, fwd_en=0, illegal_op=1.
REQ-033 in_valid=1, opcode=LOAD, sub_data=0xDEADBEEF, then clk edge -> data_to_forward_q=0xDEADBEEF and fwd_en_q=1 one cycle later; next cycle with in_valid=0 -> *_q all 0.
REQ-034 rst=1 together with in_valid=1 and opcode=OP -> after the edge *_q=0 while data_to_forward still equals main_data.
REQ-035 Apply sub_data=X with opcode=OP and main_data=0x12345678 -> data_to_forward=0x12345678 with no X.

Source files
------------

// File: rtl/data_forward_helper.sv
// Selects the RV32I rd forward value from the ALU result or the link/load result by opcode.
// Provides that value combinationally and as a one-cycle registered copy.
module data_forward_helper #(
  parameter int XLEN = 32,
  parameter int OPW  = 7    // RV32I opcode field; other widths are not supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] main_data,
  input  logic [XLEN-1:0] sub_data,
  input  logic [OPW-1:0]  opcode,
  output logic [XLEN-1:0] data_to_forward,
  output logic            fwd_en,
  output logic            illegal_op,
  output logic [XLEN-1:0] data_to_forward_q,
  output logic            fwd_en_q,
  output logic            illegal_op_q
);

  localparam logic [OPW-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPW-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPW-1:0] OP_OP_IMM = 7'b0010011;
  localparam logic [OPW-1:0] OP_OP     = 7'b0110011;
  localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPW-1:0] OP_MISC   = 7'b0001111;
  localparam logic [OPW-1:0] OP_SYSTEM = 7'b1110011;

  // Only the selected operand is referenced in each arm, so an unknown
  // value on the other operand can never reach data_to_forward.
  always_comb begin
    data_to_forward = '0;
    fwd_en          = 1'b0;
    illegal_op      = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_OP_IMM, OP_OP: begin
        data_to_forward = main_data;
        fwd_en          = 1'b1;
      end
      OP_JAL, OP_JALR, OP_LOAD: begin
        data_to_forward = sub_data;
        fwd_en          = 1'b1;
      end
      OP_BRANCH, OP_STORE, OP_MISC, OP_SYSTEM: begin
        fwd_en          = 1'b0;
      end
      default: begin
        illegal_op      = 1'b1;
      end
    endcase
  end

  // in_valid has no ready partner: a high in_valid at a rising edge captures
  // the decoded result, a low in_valid loads a zero bubble. rst wins over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_to_forward_q <= '0;
      fwd_en_q          <= 1'b0;
      illegal_op_q      <= 1'b0;
    end else if (in_valid) begin
      data_to_forward_q <= data_to_forward;
      fwd_en_q          <= fwd_en;
      illegal_op_q      <= illegal_op;
    end else begin
      data_to_forward_q <= '0;
      fwd_en_q          <= 1'b0;
      illegal_op_q      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_forward_helper.sv
// Self-checking bench for data_forward_helper: directed opcode sweeps, registered-path
// and reset cases, then randomized traffic against an opcode-table reference model.
module tb_data_forward_helper;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] main_data;
  logic [XLEN-1:0] sub_data;
  logic [6:0]      opcode;
  logic [XLEN-1:0] data_to_forward;
  logic            fwd_en;
  logic            illegal_op;
  logic [XLEN-1:0] data_to_forward_q;
  logic            fwd_en_q;
  logic            illegal_op_q;

  int total = 0;
  int bad   = 0;

  // expected registered result, packed as {data, fwd_en, illegal_op}
  logic [XLEN+1:0] exp_q[$];

  // opcode tables by category
  logic [6:0] main_ops [4] = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011};
  logic [6:0] sub_ops  [3] = '{7'b1101111, 7'b1100111, 7'b0000011};
  logic [6:0] quiet_ops[4] = '{7'b1100011, 7'b0100011, 7'b0001111, 7'b1110011};

  data_forward_helper #(.XLEN(XLEN), .OPW(7)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .main_data         (main_data),
    .sub_data          (sub_data),
    .opcode            (opcode),
    .data_to_forward   (data_to_forward),
    .fwd_en            (fwd_en),
    .illegal_op        (illegal_op),
    .data_to_forward_q (data_to_forward_q),
    .fwd_en_q          (fwd_en_q),
    .illegal_op_q      (illegal_op_q)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b0; in_valid = 1'b0; main_data = '0; sub_data = '0; opcode = '0;
  end

  function automatic bit in_list4(input logic [6:0] op, input logic [6:0] l [4]);
    for (int i = 0; i < 4; i++) if (l[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_list3(input logic [6:0] op, input logic [6:0] l [3]);
    for (int i = 0; i < 3; i++) if (l[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // reference model: returns {data, fwd_en, illegal_op}
  function automatic logic [XLEN+1:0] model(input logic [6:0] op,
                                            input logic [XLEN-1:0] m,
                                            input logic [XLEN-1:0] s);
    if (in_list4(op, main_ops)) return {m, 1'b1, 1'b0};
    if (in_list3(op, sub_ops))  return {s, 1'b1, 1'b0};
    if (in_list4(op, quiet_ops)) return {{XLEN{1'b0}}, 1'b0, 1'b0};
    return {{XLEN{1'b0}}, 1'b0, 1'b1};
  endfunction

  task automatic check_data(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, check combinational outputs, then the
  // registered outputs after the edge against the scoreboard
  task automatic step(input string tag, input logic r, input logic v, input logic [6:0] op,
                      input logic [XLEN-1:0] m, input logic [XLEN-1:0] s);
    logic [XLEN+1:0] e;
    logic [XLEN+1:0] q;
    @(negedge clk);
    rst = r; in_valid = v; opcode = op; main_data = m; sub_data = s;
    #1;
    e = model(op, m, s);
    check_data({tag, ".data"}, data_to_forward, e[XLEN+1:2]);
    check_bit({tag, ".fwd"}, fwd_en, e[1]);
    check_bit({tag, ".ill"}, illegal_op, e[0]);
    if (r || !v) exp_q.push_back('0);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    q = exp_q.pop_front();
    check_data({tag, ".data_q"}, data_to_forward_q, q[XLEN+1:2]);
    check_bit({tag, ".fwd_q"}, fwd_en_q, q[1]);
    check_bit({tag, ".ill_q"}, illegal_op_q, q[0]);
  endtask

  initial begin
    logic [6:0] op;
    logic [XLEN-1:0] m, s;

    // reset state
    step("reset", 1'b1, 1'b0, 7'b0110011, 32'h1, 32'h2);
    step("reset_v", 1'b1, 1'b1, 7'b0000011, 32'h1, 32'h2);

    // main_data opcodes
    for (int i = 0; i < 4; i++) step("main_sweep", 1'b0, 1'b1, main_ops[i], 32'h1, 32'h2);
    // sub_data opcodes
    for (int i = 0; i < 3; i++) step("sub_sweep", 1'b0, 1'b1, sub_ops[i], 32'h1, 32'h2);
    // non-writing opcodes and an illegal one
    for (int i = 0; i < 4; i++) step("quiet_sweep", 1'b0, 1'b1, quiet_ops[i], 32'h1, 32'h2);
    step("illegal_7f", 1'b0, 1'b1, 7'b1111111, 32'h1, 32'h2);
    step("illegal_00", 1'b0, 1'b1, 7'b0000000, 32'h1, 32'h2);

    // load capture then bubble
    step("load_q", 1'b0, 1'b1, 7'b0000011, 32'h0, 32'hDEADBEEF);
    step("bubble", 1'b0, 1'b0, 7'b0000011, 32'h0, 32'hDEADBEEF);

    // reset beats in_valid, combinational path unaffected
    step("rst_prio", 1'b1, 1'b1, 7'b0110011, 32'hA5A5_0F0F, 32'h5A5A_F0F0);
    step("after_rst", 1'b0, 1'b1, 7'b0110011, 32'h0BAD_CAFE, 32'h1);

    // unselected operand unknown must be masked
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; opcode = 7'b0110011; main_data = 32'h12345678; sub_data = 'x;
    #1;
    check_data("x_mask", data_to_forward, 32'h12345678);
    total++;
    assert (^data_to_forward !== 1'bx) else begin
      bad++;
      $error("FAIL x_mask_known observed=%h expected=no_x", data_to_forward);
    end
    @(posedge clk);
    #1;
    check_data("x_mask_bubble_q", data_to_forward_q, 32'h0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: op = main_ops[$urandom_range(0, 3)];
        1: op = sub_ops[$urandom_range(0, 2)];
        2: op = quiet_ops[$urandom_range(0, 3)];
        default: op = 7'($urandom_range(0, 127));
      endcase
      m = $urandom;
      s = $urandom;
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), op, m, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
